// File: rtl/conv_result_collector.sv
// Aligns core results with data_en, decimates them and buffers them in a FIFO read over the p_* bus.
// Optional threshold interrupt enabled by defining CONV_RESULT_THRESH_EN.
module conv_result_collector #(
  parameter int unsigned DATA_BITWIDTH = 16,
  parameter int unsigned PIPE_LATENCY  = 8,
  parameter int unsigned FIFO_DEPTH    = 64
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [DATA_BITWIDTH-1:0] data_res,
  input  logic                     data_en,
  input  logic                     p_sel,
  input  logic [3:0]               p_strb,
  input  logic [31:0]              p_addr,
  input  logic [31:0]              p_wdata,
  input  logic                     p_ce,
  input  logic                     p_we,
  output logic                     p_rdy,
  output logic [31:0]              p_rdata,
  output logic                     fifo_nempty,
  output logic                     irq
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_e;

  state_e                    state_q, state_d;
  logic [PIPE_LATENCY-1:0]   en_pipe_q, en_pipe_d;
  logic                      ctrl_en_q, ctrl_en_d;
  logic [15:0]               decim_q, decim_d;
  logic [15:0]               dcnt_q, dcnt_d;
  logic [PW-1:0]             wptr_q, wptr_d, rptr_q, rptr_d;
  logic                      ovf_q, ovf_d;
  logic                      irq_q, irq_d;
  logic                      p_rdy_q, p_rdy_d;
  logic [31:0]               p_rdata_q, p_rdata_d;
  logic                      nempty_q, nempty_d;
  logic [DATA_BITWIDTH-1:0]  mem_q [FIFO_DEPTH];
`ifdef CONV_RESULT_THRESH_EN
  logic [15:0]               thresh_q, thresh_d;
`endif

  logic          sample_c, empty_c, full_c, wr_c, rd_c;
  logic          push_req_c, push_ok_c, pop_c, flush_c;
  logic          addr_ctrl_c, addr_decim_c, addr_stat_c, addr_data_c;
  logic [PW-1:0] level_c;
  logic [15:0]   decim_eff_c;
  logic [31:0]   status_c, rdata_c;
  logic          unused_c;

  assign unused_c     = ^{p_strb, p_wdata};
  assign sample_c     = en_pipe_q[PIPE_LATENCY-1];
  assign level_c      = wptr_q - rptr_q;
  assign empty_c      = (wptr_q == rptr_q);
  assign full_c       = (level_c == PW'(FIFO_DEPTH));
  assign wr_c         = (state_q == S_WRITE) && p_ce;
  assign rd_c         = (state_q == S_READ) && p_ce;
  assign addr_ctrl_c  = (p_addr == 32'd0);
  assign addr_decim_c = (p_addr == 32'd1);
  assign addr_stat_c  = (p_addr == 32'd2);
  assign addr_data_c  = (p_addr == 32'd3);
  assign decim_eff_c  = (decim_q == 16'd0) ? 16'd1 : decim_q;
  assign push_req_c   = sample_c && ctrl_en_q && (dcnt_q == 16'd0);
  assign push_ok_c    = push_req_c && !full_c;
  assign pop_c        = rd_c && addr_data_c && !empty_c;
  assign flush_c      = wr_c && addr_ctrl_c && p_wdata[1];

  // Register read mux; DATA reads 0 when the FIFO is empty
  always_comb begin
    status_c        = 32'(level_c);
    status_c[16]    = empty_c;
    status_c[17]    = full_c;
    status_c[18]    = ovf_q;
    status_c[19]    = irq_q;
    rdata_c         = '0;
    case (p_addr)
      32'd0:   rdata_c = 32'(ctrl_en_q);
      32'd1:   rdata_c = 32'(decim_q);
      32'd2:   rdata_c = status_c;
      32'd3:   rdata_c = empty_c ? 32'd0 : 32'(mem_q[rptr_q[AW-1:0]]);
`ifdef CONV_RESULT_THRESH_EN
      32'd4:   rdata_c = 32'(thresh_q);
`endif
      default: rdata_c = '0;
    endcase
  end

  // Bus FSM, register updates, decimation and FIFO pointers
  always_comb begin
    state_d   = state_q;
    p_rdy_d   = 1'b0;
    p_rdata_d = '0;
    ctrl_en_d = ctrl_en_q;
    decim_d   = decim_q;
    dcnt_d    = dcnt_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    ovf_d     = ovf_q;
    irq_d     = 1'b0;
    en_pipe_d = {PIPE_LATENCY{1'b0}};
    en_pipe_d[0] = data_en;
    for (int i = 1; i < PIPE_LATENCY; i++) en_pipe_d[i] = en_pipe_q[i-1];

    case (state_q)
      S_IDLE:  if (p_sel) state_d = p_we ? S_WRITE : S_READ;
      S_WRITE,
      S_READ:  if (p_ce) begin
                 state_d   = S_IDLE;
                 p_rdy_d   = 1'b1;
                 p_rdata_d = rd_c ? rdata_c : 32'd0;
               end
      default: state_d = S_IDLE;
    endcase

    if (sample_c && ctrl_en_q) begin
      if (32'(dcnt_q) + 32'd1 >= 32'(decim_eff_c)) dcnt_d = '0;
      else                                         dcnt_d = dcnt_q + 16'd1;
    end
    if (wr_c && ((addr_ctrl_c && p_wdata[0] && !ctrl_en_q) || addr_decim_c)) dcnt_d = '0;

    if (wr_c) begin
      if (addr_ctrl_c) ctrl_en_d = p_wdata[0];
      if (addr_decim_c) decim_d = p_wdata[15:0];
      if (addr_stat_c && p_wdata[18]) ovf_d = 1'b0;
    end
    if (push_req_c && full_c) ovf_d = 1'b1;

    if (flush_c) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push_ok_c) wptr_d = wptr_q + PW'(1);
      if (pop_c)     rptr_d = rptr_q + PW'(1);
    end
    nempty_d = (wptr_d != rptr_d);

`ifdef CONV_RESULT_THRESH_EN
    thresh_d = thresh_q;
    irq_d    = irq_q;
    if (wr_c && (p_addr == 32'd4)) thresh_d = p_wdata[15:0];
    if (wr_c && addr_stat_c && p_wdata[19]) irq_d = 1'b0;
    if (push_ok_c && (32'(data_res) > 32'(thresh_q))) irq_d = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      en_pipe_q <= '0;
      ctrl_en_q <= 1'b0;
      decim_q   <= 16'd1;
      dcnt_q    <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      ovf_q     <= 1'b0;
      irq_q     <= 1'b0;
      p_rdy_q   <= 1'b0;
      p_rdata_q <= '0;
      nempty_q  <= 1'b0;
`ifdef CONV_RESULT_THRESH_EN
      thresh_q  <= 16'hFFFF;
`endif
    end else begin
      state_q   <= state_d;
      en_pipe_q <= en_pipe_d;
      ctrl_en_q <= ctrl_en_d;
      decim_q   <= decim_d;
      dcnt_q    <= dcnt_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      ovf_q     <= ovf_d;
      irq_q     <= irq_d;
      p_rdy_q   <= p_rdy_d;
      p_rdata_q <= p_rdata_d;
      nempty_q  <= nempty_d;
`ifdef CONV_RESULT_THRESH_EN
      thresh_q  <= thresh_d;
`endif
    end
  end

  // Storage needs no reset; the pointers define what is valid
  always_ff @(posedge clk) begin
    if (push_ok_c && !flush_c) mem_q[wptr_q[AW-1:0]] <= data_res;
  end

  assign p_rdy       = p_rdy_q;
  assign p_rdata     = p_rdata_q;
  assign fifo_nempty = nempty_q;
  assign irq         = irq_q;

endmodule
